// File: rtl/pulse_train_pkg.sv
// -----------------------------------------------------------------------------
// pulse_train_pkg
// Shared types and default sizes for the pulse-train generator.
//   state_e      : FSM state encoding (IDLE, HIGH, LOW, DONE)
//   DEFAULT_W    : default bit width of the width/gap inputs
//   DEFAULT_N    : default bit width of the count input
// -----------------------------------------------------------------------------
package pulse_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_W = 8;
  localparam int DEFAULT_N = 8;

endpackage : pulse_train_pkg

// File: rtl/phase_down_counter.sv
// -----------------------------------------------------------------------------
// phase_down_counter
// Loadable down-counter with a flag that marks its final count.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (value -> 0)
//   load     : load load_val (has priority over dec)
//   dec      : decrement by one; holds at zero
//   load_val : value to load, WIDTH bits
//   last     : high while the counter holds 1 (final cycle of the run)
// -----------------------------------------------------------------------------
module phase_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] value_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (dec && (value_q != '0)) begin
      value_q <= value_q - WIDTH'(1);
    end
  end

  assign last = (value_q == WIDTH'(1));

endmodule : phase_down_counter

// File: rtl/pulse_train_generator.sv
// -----------------------------------------------------------------------------
// pulse_train_generator
// On start, emits `count` high pulses of `width` cycles separated by `gap`
// low cycles on a registered output, then strobes done for one cycle.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, sampled only while not busy (IDLE or DONE)
//   width  : high-phase length in cycles (0 treated as 1), W bits
//   gap    : low-phase length in cycles (0 treated as 1), W bits
//   count  : number of pulses, N bits (0 -> immediate done)
//   abort  : cancel an active train (only with PULSE_TRAIN_ABORT_EN)
//   out    : registered pulse-train output
//   busy   : a train is in progress
//   done   : single-cycle completion strobe
// Build option: define PULSE_TRAIN_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] width,
  input  logic [W-1:0] gap,
  input  logic [N-1:0] count,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic         abort,
`endif
  output logic         out,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [W-1:0] width_q, width_d;
  logic [W-1:0] gap_q, gap_d;
  logic         out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Phase counter: cycles left in the current HIGH or LOW phase.
  logic         ph_load, ph_dec, ph_last;
  logic [W-1:0] ph_val;
  // Pulse counter: pulses left, including the one in progress.
  logic         pc_load, pc_dec, pc_last;

  logic         abort_req;
  logic [W-1:0] width_eff, gap_eff;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // A zero-length phase would never end, so it is stretched to one cycle.
  assign width_eff = (width == '0) ? W'(1) : width;
  assign gap_eff   = (gap   == '0) ? W'(1) : gap;

  phase_down_counter #(.WIDTH(W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .dec      (ph_dec),
    .load_val (ph_val),
    .last     (ph_last)
  );

  phase_down_counter #(.WIDTH(N)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .dec      (pc_dec),
    .load_val (count),
    .last     (pc_last)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    gap_d   = gap_q;
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = width_q;
    pc_load = 1'b0;
    pc_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE lasts one cycle but accepts start exactly like IDLE, which
        // gives back-to-back trains with a single low cycle between them.
        state_d = ST_IDLE;
        if (start) begin
          width_d = width_eff;
          gap_d   = gap_eff;
          if (count != '0) begin
            state_d = ST_HIGH;
            ph_load = 1'b1;
            ph_val  = width_eff;
            pc_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_HIGH: begin
        ph_dec = 1'b1;
        if (ph_last) begin
          pc_dec = 1'b1;
          if (pc_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOW;
            ph_load = 1'b1;
            ph_val  = gap_q;
          end
        end
      end

      ST_LOW: begin
        ph_dec = 1'b1;
        if (ph_last) begin
          state_d = ST_HIGH;
          ph_load = 1'b1;
          ph_val  = width_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any phase transition; counters are reloaded on the
    // next start, so their residual values do not matter.
    if (abort_req && ((state_q == ST_HIGH) || (state_q == ST_LOW))) begin
      state_d = ST_IDLE;
      ph_load = 1'b0;
      pc_dec  = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe and never glitch.
  always_comb begin
    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : pulse_train_generator

// File: tb/tb_pulse_train_generator.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_generator
// Directed self-checking bench for pulse_train_generator (default W=N=8).
// Build option: define PULSE_TRAIN_ABORT_EN to also exercise abort.
// Inputs are driven and outputs sampled on the falling clock edge. Traces are
// indexed from cycle T+1, where T is the rising edge that accepts start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_train_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] width;
  logic [7:0] gap;
  logic [7:0] count;
  logic       out;
  logic       busy;
  logic       done;
`ifdef PULSE_TRAIN_ABORT_EN
  logic       abort;
`endif

  int total;
  int bad;

  pulse_train_generator #(.W(8), .N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .width (width),
    .gap   (gap),
    .count (count),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort (abort),
`endif
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requests one train, then records out/busy/done for n cycles starting at
  // T+1. After the accepting edge the inputs switch to the alternate values
  // and start follows smask (bit i drives start during cycle T+1+i).
  task automatic run_trace(input logic [7:0] w, input logic [7:0] g,
                           input logic [7:0] c, input logic [15:0] smask,
                           input logic [7:0] aw, input logic [7:0] ag,
                           input logic [7:0] ac, input int n,
                           output logic [15:0] o_tr, output logic [15:0] b_tr,
                           output logic [15:0] d_tr);
    o_tr = '0;
    b_tr = '0;
    d_tr = '0;
    @(negedge clk);
    width = w;
    gap   = g;
    count = c;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o_tr[i] = out;
      b_tr[i] = busy;
      d_tr[i] = done;
      start   = smask[i];
      width   = aw;
      gap     = ag;
      count   = ac;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if ({out, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: out/busy/done=%b expected 000", {out, busy, done});
    end
  endtask

  task automatic test_reset_mid_train;
    logic seen;
    @(negedge clk);
    width = 8'd4;
    gap   = 8'd1;
    count = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({out, busy} !== 2'b11) begin
      bad++;
      $display("FAIL rst_pre: out/busy=%b expected 11", {out, busy});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async: out/busy/done=%b expected 000", {out, busy, done});
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || out || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_done: activity seen=%b expected 0", seen);
    end
  endtask

  task automatic test_single_pulse;
    logic [15:0] o_tr, b_tr, d_tr;
    total++;
    if (out !== 1'b0) begin
      bad++;
      $display("FAIL single_pre: out=%b expected 0", out);
    end
    run_trace(8'd1, 8'd1, 8'd1, 16'h0, 8'd1, 8'd1, 8'd1, 4, o_tr, b_tr, d_tr);
    total++;
    if (o_tr !== 16'h0001) begin
      bad++;
      $display("FAIL single_out: got %h expected 0001", o_tr);
    end
    total++;
    if (b_tr !== 16'h0001) begin
      bad++;
      $display("FAIL single_busy: got %h expected 0001", b_tr);
    end
    total++;
    if (d_tr !== 16'h0002) begin
      bad++;
      $display("FAIL single_done: got %h expected 0002", d_tr);
    end
  endtask

  task automatic test_multi_pulse;
    logic [15:0] o_tr, b_tr, d_tr;
    // w=3 g=2 c=2: high T+1..T+3, low T+4..T+5, high T+6..T+8, done T+9.
    run_trace(8'd3, 8'd2, 8'd2, 16'h0, 8'd3, 8'd2, 8'd2, 10, o_tr, b_tr, d_tr);
    total++;
    if (o_tr !== 16'h00E7) begin
      bad++;
      $display("FAIL multi_out: got %h expected 00e7", o_tr);
    end
    total++;
    if (b_tr !== 16'h00FF) begin
      bad++;
      $display("FAIL multi_busy: got %h expected 00ff", b_tr);
    end
    total++;
    if (d_tr !== 16'h0100) begin
      bad++;
      $display("FAIL multi_done: got %h expected 0100", d_tr);
    end
  endtask

  task automatic test_zero_handling;
    logic [15:0] o_tr, b_tr, d_tr;
    // width=0, gap=0 behave as 1: out 1,0,1 then done.
    run_trace(8'd0, 8'd0, 8'd2, 16'h0, 8'd0, 8'd0, 8'd2, 5, o_tr, b_tr, d_tr);
    total++;
    if (o_tr !== 16'h0005) begin
      bad++;
      $display("FAIL zero_wg_out: got %h expected 0005", o_tr);
    end
    total++;
    if (b_tr !== 16'h0007) begin
      bad++;
      $display("FAIL zero_wg_busy: got %h expected 0007", b_tr);
    end
    total++;
    if (d_tr !== 16'h0008) begin
      bad++;
      $display("FAIL zero_wg_done: got %h expected 0008", d_tr);
    end
    // count=0: no pulse, done at T+1.
    run_trace(8'd5, 8'd1, 8'd0, 16'h0, 8'd5, 8'd1, 8'd0, 3, o_tr, b_tr, d_tr);
    total++;
    if ((o_tr | b_tr) !== 16'h0000) begin
      bad++;
      $display("FAIL zero_cnt_out: out|busy got %h expected 0000", o_tr | b_tr);
    end
    total++;
    if (d_tr !== 16'h0001) begin
      bad++;
      $display("FAIL zero_cnt_done: got %h expected 0001", d_tr);
    end
  endtask

  task automatic test_start_while_busy;
    logic [15:0] o_tr, b_tr, d_tr;
    // w=2 g=1 c=2; start re-pulsed during T+2..T+4 with w=7 g=3 c=5.
    run_trace(8'd2, 8'd1, 8'd2, 16'h000E, 8'd7, 8'd3, 8'd5, 8, o_tr, b_tr, d_tr);
    total++;
    if (o_tr !== 16'h001B) begin
      bad++;
      $display("FAIL busy_ign_out: got %h expected 001b", o_tr);
    end
    total++;
    if (b_tr !== 16'h001F) begin
      bad++;
      $display("FAIL busy_ign_busy: got %h expected 001f", b_tr);
    end
    total++;
    if (d_tr !== 16'h0020) begin
      bad++;
      $display("FAIL busy_ign_done: got %h expected 0020", d_tr);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] o_tr, b_tr, d_tr;
    // Train 1: w=1 c=1 (high T+1, done T+2). Start held through DONE with
    // w=2 c=1: high T+3..T+4, done T+5; T+2 is the single low separator.
    run_trace(8'd1, 8'd1, 8'd1, 16'h0003, 8'd2, 8'd1, 8'd1, 7, o_tr, b_tr, d_tr);
    total++;
    if (o_tr !== 16'h000D) begin
      bad++;
      $display("FAIL b2b_out: got %h expected 000d", o_tr);
    end
    total++;
    if (b_tr !== 16'h000D) begin
      bad++;
      $display("FAIL b2b_busy: got %h expected 000d", b_tr);
    end
    total++;
    if (d_tr !== 16'h0012) begin
      bad++;
      $display("FAIL b2b_done: got %h expected 0012", d_tr);
    end
  endtask

`ifdef PULSE_TRAIN_ABORT_EN
  task automatic test_abort;
    logic seen;
    @(negedge clk);
    width = 8'd5;
    gap   = 8'd1;
    count = 8'd2;
    start = 1'b1;
    @(negedge clk);          // T+1, first high cycle
    start = 1'b0;
    @(negedge clk);          // T+2, second high cycle
    total++;
    if (out !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: out=%b expected 1", out);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({out, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_stop: out/busy/done=%b expected 000", {out, busy, done});
    end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || out || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: activity seen=%b expected 0", seen);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    width = '0;
    gap   = '0;
    count = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;

    test_single_pulse;
    test_multi_pulse;
    test_zero_handling;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_train;
`ifdef PULSE_TRAIN_ABORT_EN
    test_abort;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pulse_train_generator

// File: doc/pulse_train_generator.md
# pulse_train_generator

Programmable pulse-train source for the sequential-basics block set: on a start request it drives a registered single-bit output with `count` high pulses, each `width` cycles long and separated by `gap` low cycles, then reports completion. It is the stimulus side of the edge/pulse detection blocks: it produces the `0→1→0` patterns those blocks detect, so any pulse it emits with width 1 is a one-cycle (010) pulse.

## Interface
Parameters:
- `W`, default 8: bit width of `width` and `gap`.
- `N`, default 8: bit width of `count`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; sampled only while `busy`=0.
- `width`, input, W: high-phase length in cycles; 0 is treated as 1.
- `gap`, input, W: low-phase length between pulses; 0 is treated as 1.
- `count`, input, N: number of pulses.
- `out`, output, 1: registered pulse-train output.
- `busy`, output, 1: a train is in progress.
- `done`, output, 1: single-cycle completion strobe.
- `abort`, input, 1: present only with `PULSE_TRAIN_ABORT_EN` (see Configuration).

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE: `out`=0, `busy`=0. If `start`=1, latch `width`, `gap` and `count` (zero substitution applied at latch).
  - count>0: go to HIGH, load the phase counter with width and the pulse counter with count.
  - count=0: go to DONE, no pulse.
- HIGH: `out`=1 for the latched width. At its last cycle, decrement the pulse counter.
  - Pulses remain: go to LOW.
  - Otherwise: go to DONE.
- LOW: `out`=0 for the latched gap, then go to HIGH.
- DONE: `done`=1, `busy`=0, `out`=0 for exactly one cycle. `start` is accepted here with the same rules as IDLE; otherwise go to IDLE.
- `start` while `busy`=1 is ignored. Inputs are not re-sampled mid-train.
- Counters are down-counters. Phase-counter width is W; pulse-counter width is N; no wrap-around is possible.
- `rst` mid-train: immediate return to IDLE and all outputs 0. No `done` is generated.

## Timing
- All outputs are registered. Reset values: `out`=0, `busy`=0, `done`=0, state IDLE.
- Start accepted at clock edge T gives:
  - `out`=1 and `busy`=1 from cycle T+1.
  - `out` high for width cycles, then low for gap cycles, repeating.
  - `busy` stays high through the last high cycle.
- `done` is asserted in the cycle immediately after the last high cycle.
- Total cycles from T+1 to `done` = count·width + (count−1)·gap. For count=0, `done` is at T+1.
- Back-to-back trains: a start in the DONE cycle drives `out`=1 in the next cycle. The two trains are separated by exactly one low cycle.

## Configuration
- `PULSE_TRAIN_ABORT_EN` defined:
  - Adds input `abort`.
  - `abort`=1 while `busy`=1 forces IDLE at the next edge, with `out`=0 and `busy`=0 in the following cycle. No `done`.
  - `abort` in IDLE or DONE has no effect.
  - Reset has priority over abort; abort has priority over phase transitions.
- Not defined: no `abort` port. The train always runs to completion or reset.

## Structure
- `pulse_train_pkg` holds:
  - the state enum typedef (IDLE, HIGH, LOW, DONE);
  - default `W` and `N` localparams.
- Sub-module `phase_down_counter`: parameterized loadable down-counter with a `last` flag. It is instantiated twice, for phase (W) and pulse count (N).

## Test plan
- Reset: assert `rst` mid-train (width=4, count=3) → same cycle `out`=0, `busy`=0, `done`=0; no `done` afterwards.
- width=1, gap=1, count=1, start at T → `out` pattern 0,1,0 (high at T+1 only); `done`=1 at T+2.
- width=3, gap=2, count=2, start at T → `out` high T+1..T+3, low T+4..T+5, high T+6..T+8; `busy` T+1..T+8; `done` at T+9.
- Zero handling:
  - width=0, gap=0, count=2 → `out` 1,0,1.
  - count=0 → no high cycle, `done` at T+1.
- `start` pulsed while busy with different inputs → ignored, train unchanged.
- Start held high through DONE → second train begins the cycle after `done` with one low cycle between trains.
- With `PULSE_TRAIN_ABORT_EN`, `abort` at the 2nd high cycle of a width=5 pulse → `out`=0 and `busy`=0 next cycle, no `done`.
